pipelined_adder_sub: RTL and testbench
======================================

// Module: pipelined_adder_sub
//
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor, the successor of the 4-bit ripple adder.
//  The carry chain is split into STAGES equal slices with one register boundary per slice.
//  Accepts one operation per clock through a valid/ready handshake; returns sum, carry and signed overflow.
//  Sits between operand sources (ALU front end, accumulators) and any back-pressuring consumer.
//
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = carry-chain slices; 1 <= STAGES <= WIDTH
//
// PORTS
//  i_clk        in   1      single clock, all state on rising edge
//  i_rst        in   1      reset, asynchronous, active-high
//  i_valid      in   1      operation presented on i_op1/i_op2/i_carry_in/i_sub
//  o_ready      out  1      block can accept; transfer when i_valid & o_ready
//  i_op1        in   WIDTH  operand A
//  i_op2        in   WIDTH  operand B
//  i_carry_in   in   1      carry-in (add) / borrow-in (sub)
//  i_sub        in   1      0: A+B+cin   1: A-B-cin
//  o_valid      out  1      result valid
//  i_ready      in   1      consumer accepts; transfer when o_valid & i_ready
//  o_sum        out  WIDTH  result
//  o_carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
//  o_overflow   out  1      signed overflow of result
//
// BEHAVIOUR
//  - Reset: all valid bits, o_valid, o_sum, o_carry_out, o_overflow = 0; o_ready = 1 during/after reset.
//  - Reset mid-operation: in-flight ops discarded immediately; nothing emerges after deassertion.
//  - Sub mode: B replaced by ~B, carry-in replaced by ~i_carry_in (A + ~B + ~cin); done at input stage.
//  - Slice k (k=0..STAGES-1) adds bits [k*C +: C], C = WIDTH/STAGES, with carry from slice k-1 registered.
//  - Unused upper operand slices are delayed alongside; finished lower sum slices are delayed to realign.
//  - Latency: accepted op appears on o_valid exactly STAGES cycles later when no stall; throughput 1/cycle.
//  - Stall: global. stall = o_valid & ~i_ready. On stall every pipeline register and valid bit holds.
//  - o_ready = ~stall (combinational); bubbles are not collapsed.
//  - Outputs held stable while o_valid & ~i_ready (no change, no drop).
//  - o_carry_out = carry out of bit WIDTH-1; o_overflow = carry into MSB XOR carry out of MSB.
//  - Simultaneous output accept and input accept in the same cycle: both transfer, pipe advances.
//  - STAGES=1: one register stage, behaviour otherwise identical.
//
// STRUCTURE
//  - Shared package: op-mode constants (OP_ADD=1'b0, OP_SUB=1'b1); no typedefs required.
//  - One sub-module: adder_slice (parametrised C-bit ripple adder, comb; a, b, cin -> sum, cout, c_msb).
//  - Top: generate loop of STAGES adder_slice instances, skew/deskew registers, valid shift chain, stall.
//  - Elaboration check: error if WIDTH % STAGES != 0.
//
// TESTING (WIDTH=16, STAGES=4)
//  - Add 0xFFFF + 0x0001, cin=0 -> after 4 clk: sum 0x0000, carry 1, overflow 0.
//  - Add 0x7FFF + 0x0001, cin=0 -> sum 0x8000, carry 0, overflow 1.
//  - Sub 0x0005 - 0x0007, cin=0 -> sum 0xFFFE, carry 0 (borrow), overflow 0; sub 0x8000-0x0001 -> 0x7FFF, ovf 1.
//  - 8 back-to-back random ops, i_ready=1 -> 8 results on consecutive cycles, first at +4, all match model.
//  - i_ready low 3 cycles with o_valid=1 -> o_ready=0, o_sum stable, no loss/duplication after release.
//  - i_rst pulsed with 3 ops in flight -> o_valid=0 at once, no result emerges in next 8 cycles.

Source files
------------

// File: rtl/pipelined_adder_sub_pkg.sv
// rtl/pipelined_adder_sub_pkg.sv - shared op-mode constants for the pipelined adder/subtractor
package pipelined_adder_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_sub_if.sv
// rtl/pipelined_adder_sub_if.sv - operand/result handshake bundle for the pipelined adder/subtractor
interface pipelined_adder_sub_if #(
    parameter int WIDTH = 16
);
    import pipelined_adder_sub_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             i_carry_in;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry_out;
    logic             o_overflow;

    // Operand source and result consumer side.
    modport master (
        output i_valid, i_op1, i_op2, i_carry_in, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_carry_out, o_overflow
    );

    // Adder side.
    modport slave (
        input  i_valid, i_op1, i_op2, i_carry_in, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_carry_out, o_overflow
    );

endinterface

// File: rtl/pipelined_adder_sub_adder_slice.sv
// rtl/pipelined_adder_sub_adder_slice.sv - combinational C-bit ripple-carry slice
module adder_slice #(
    parameter int C = 4
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    import pipelined_adder_sub_pkg::*;

    logic carry;

    // Ripple the carry bit by bit; c_msb is the carry entering the top bit of the slice.
    always_comb begin
        carry = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < C; i++) begin
            if (i == C - 1) begin
                c_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_adder_sub.sv
// rtl/pipelined_adder_sub.sv - STAGES-deep pipelined two's-complement adder/subtractor
module pipelined_adder_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipelined_adder_sub_if.slave bus
);
    import pipelined_adder_sub_pkg::*;

    localparam int C = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic stall;

    // Whole pipe freezes while a finished result waits on the consumer.
    assign stall       = bus.o_valid & ~bus.i_ready;
    assign bus.o_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [WIDTH-1:0] a_in, b_in, s_in, s_next;
        logic             c_in, v_in;
        logic [C-1:0]     slice_sum;
        logic             slice_cout, slice_cmsb;

        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic             c_q, ovf_q, v_q;

        if (k == 0) begin : g_first
            // Subtraction is folded in here: A + ~B + ~borrow_in.
            assign a_in = bus.i_op1;
            assign b_in = (bus.i_sub == OP_SUB) ? ~bus.i_op2 : bus.i_op2;
            assign c_in = (bus.i_sub == OP_SUB) ? ~bus.i_carry_in : bus.i_carry_in;
            assign s_in = '0;
            assign v_in = bus.i_valid;
        end else begin : g_rest
            assign a_in = stg[k-1].a_q;
            assign b_in = stg[k-1].b_q;
            assign c_in = stg[k-1].c_q;
            assign s_in = stg[k-1].s_q;
            assign v_in = stg[k-1].v_q;
        end

        adder_slice #(.C(C)) u_slice (
            .a     (a_in[k*C +: C]),
            .b     (b_in[k*C +: C]),
            .cin   (c_in),
            .sum   (slice_sum),
            .cout  (slice_cout),
            .c_msb (slice_cmsb)
        );

        // Merge this slice's bits into the sum already finished by lower slices.
        always_comb begin
            s_next              = s_in;
            s_next[k*C +: C]    = slice_sum;
        end

        // Stage register: operands, partial sum, carry and valid advance together unless stalled.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
                v_q   <= 1'b0;
            end else if (!stall) begin
                a_q   <= a_in;
                b_q   <= b_in;
                s_q   <= s_next;
                c_q   <= slice_cout;
                ovf_q <= slice_cout ^ slice_cmsb;
                v_q   <= v_in;
            end
        end
    end

    assign bus.o_valid     = stg[STAGES-1].v_q;
    assign bus.o_sum       = stg[STAGES-1].s_q;
    assign bus.o_carry_out = stg[STAGES-1].c_q;
    assign bus.o_overflow  = stg[STAGES-1].ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb/tb_pipelined_adder_sub.sv - directed self-checking bench for pipelined_adder_sub
module tb_pipelined_adder_sub;
    import pipelined_adder_sub_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipelined_adder_sub_if #(.WIDTH(16)) bus ();

    pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.i_valid    = 1'b0;
        bus.i_op1      = '0;
        bus.i_op2      = '0;
        bus.i_carry_in = 1'b0;
        bus.i_sub      = OP_ADD;
    endtask

    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bus.i_valid    = 1'b1;
        bus.i_op1      = a;
        bus.i_op2      = b;
        bus.i_carry_in = cin;
        bus.i_sub      = sub;
    endtask

    task automatic check_result(input string name, input logic [15:0] es, input logic ec, input logic eo);
        total++;
        if ({bus.o_valid, bus.o_sum, bus.o_carry_out, bus.o_overflow} !== {1'b1, es, ec, eo}) begin
            bad++;
            $display("FAIL %s: got valid=%b sum=%h c=%b ovf=%b, want valid=1 sum=%h c=%b ovf=%b",
                     name, bus.o_valid, bus.o_sum, bus.o_carry_out, bus.o_overflow, es, ec, eo);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.i_ready = 1'b1;
        #12;
        total++;
        if ({bus.o_valid, bus.o_sum, bus.o_carry_out, bus.o_overflow, bus.o_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: valid=%b sum=%h c=%b ovf=%b ready=%b, want 0 0000 0 0 1",
                     bus.o_valid, bus.o_sum, bus.o_carry_out, bus.o_overflow, bus.o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One op, then exact-latency check: absent after 3 clocks, present after 4.
    task automatic single_op(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub,
                             input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        drive_op(a, b, cin, sub);
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
        check_bit({name, "_early"}, bus.o_valid, 1'b0);
        @(negedge clk);
        check_result(name, es, ec, eo);
        @(negedge clk);
        check_bit({name, "_drain"}, bus.o_valid, 1'b0);
    endtask

    task automatic test_arith();
        single_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
        single_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
        single_op("sub_5_7",    16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
        single_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1);
        single_op("add_cin",    16'h1234, 16'h0001, 1'b1, OP_ADD, 16'h1236, 1'b0, 1'b0);
        single_op("sub_bin",    16'h0010, 16'h0001, 1'b1, OP_SUB, 16'h000E, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h8000, 16'h1000, 16'h0000, 16'hABCD, 16'h7FFF};
        logic [15:0] vb [8] = '{16'h0002, 16'h0001, 16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h1234, 16'hFFFF};
        logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vs [8] = '{OP_ADD, OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_SUB};
        logic [15:0] es [8] = '{16'h0003, 16'h0100, 16'h1000, 16'h0000, 16'h0FFF, 16'hFFFF, 16'hBE02, 16'h8000};
        logic        ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            if (t >= 4 && t < 12) begin
                check_result($sformatf("b2b_%0d", t - 4), es[t-4], ec[t-4], eo[t-4]);
            end else begin
                check_bit($sformatf("b2b_idle_%0d", t), bus.o_valid, 1'b0);
            end
            check_bit($sformatf("b2b_ready_%0d", t), bus.o_ready, 1'b1);
            if (t < 8) drive_op(va[t], vb[t], vc[t], vs[t]);
            else       drive_idle();
        end
    endtask

    task automatic test_stall();
        bus.i_ready = 1'b0;
        @(negedge clk); drive_op(16'h0011, 16'h0022, 1'b0, OP_ADD);
        @(negedge clk); drive_op(16'h0100, 16'h0001, 1'b0, OP_SUB);
        @(negedge clk); drive_op(16'hFFFF, 16'hFFFF, 1'b0, OP_ADD);
        @(negedge clk); drive_idle();
        check_bit("stall_prefill_ready", bus.o_ready, 1'b1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check_result($sformatf("stall_hold_%0d", t), 16'h0033, 1'b0, 1'b0);
            check_bit($sformatf("stall_ready_%0d", t), bus.o_ready, 1'b0);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        check_result("stall_rel_b", 16'h00FF, 1'b1, 1'b0);
        @(negedge clk);
        check_result("stall_rel_c", 16'hFFFE, 1'b1, 1'b0);
        @(negedge clk);
        check_bit("stall_no_dup", bus.o_valid, 1'b0);
    endtask

    task automatic test_reset_inflight();
        bus.i_ready = 1'b1;
        @(negedge clk); drive_op(16'h0001, 16'h0001, 1'b0, OP_ADD);
        @(negedge clk); drive_op(16'h0002, 16'h0002, 1'b0, OP_ADD);
        @(negedge clk); drive_op(16'h0003, 16'h0003, 1'b0, OP_ADD);
        @(negedge clk); drive_idle();
        bus.i_ready = 1'b0;
        @(negedge clk);
        check_result("rst_pre", 16'h0002, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_bit("rst_async_valid", bus.o_valid, 1'b0);
        check_bit("rst_async_ready", bus.o_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check_bit($sformatf("rst_quiet_%0d", t), bus.o_valid, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
